// File: rtl/picorv_mem_responder.sv
// ============================================================================
// picorv_mem_responder
// PicoRV32 native memory bus to single-port synchronous RAM bridge; handles
// reads, full-word writes and byte-strobed read-modify-write.
// Revision: 1.0
// ============================================================================
`default_nettype none

module picorv_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        ram_wen,
  output logic [7:0]  ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ADDR   = 3'd1,
    RD_CAP    = 3'd2,
    WR_COMMIT = 3'd3,
    RMW_ADDR  = 3'd4,
    RMW_READ  = 3'd5,
    RMW_WRITE = 3'd6,
    ACK       = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_mem_ready;
  logic [31:0] r_mem_rdata;
  logic        r_ram_wen;
  logic [7:0]  r_ram_addr;
  logic [31:0] r_ram_wdata;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  logic        w_mem_ready_nxt;
  logic [31:0] w_mem_rdata_nxt;
  logic        w_ram_wen_nxt;
  logic [7:0]  w_ram_addr_nxt;
  logic [31:0] w_ram_wdata_nxt;
  logic [31:0] w_wdata_nxt;
  logic [3:0]  w_wstrb_nxt;

  logic        w_sel;
  logic        w_unused;

  assign w_sel    = mem_valid && (mem_addr[31:10] == BASE_ADDR[31:10]);
  // Byte offset bits never influence a word-wide access.
  assign w_unused = &{1'b0, mem_addr[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ram_wen_nxt   = 1'b0;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_wdata_nxt = r_ram_wdata;
    w_mem_rdata_nxt = r_mem_rdata;
    w_wdata_nxt     = r_wdata;
    w_wstrb_nxt     = r_wstrb;

    case (r_state)
      IDLE: begin
        if (w_sel) begin
          w_ram_addr_nxt = mem_addr[9:2];
          w_wdata_nxt    = mem_wdata;
          w_wstrb_nxt    = mem_wstrb;
          if (mem_wstrb == 4'h0) begin
            w_state_nxt = RD_ADDR;
          end else if (mem_wstrb == 4'hF) begin
            w_ram_wdata_nxt = mem_wdata;
            w_ram_wen_nxt   = 1'b1;
            w_state_nxt     = WR_COMMIT;
          end else begin
            w_state_nxt = RMW_ADDR;
          end
        end
      end
      RD_ADDR:   w_state_nxt = RD_CAP;
      RD_CAP: begin
        w_mem_rdata_nxt = ram_rdata;
        w_state_nxt     = ACK;
      end
      WR_COMMIT: w_state_nxt = ACK;
      RMW_ADDR:  w_state_nxt = RMW_READ;
      RMW_READ: begin
        // Strobed bytes come from the CPU, the rest from the old RAM word.
        for (int i = 0; i < 4; i++) begin
          w_ram_wdata_nxt[8*i +: 8] = r_wstrb[i] ? r_wdata[8*i +: 8]
                                                 : ram_rdata[8*i +: 8];
        end
        w_ram_wen_nxt = 1'b1;
        w_state_nxt   = WR_COMMIT;
      end
      ACK:       w_state_nxt = IDLE;
      RMW_WRITE: w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase

    w_mem_ready_nxt = (w_state_nxt == ACK);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem_ready <= 1'b0;
      r_mem_rdata <= 32'h0;
      r_ram_wen   <= 1'b0;
      r_ram_addr  <= 8'h0;
      r_ram_wdata <= 32'h0;
      r_wdata     <= 32'h0;
      r_wstrb     <= 4'h0;
    end else begin
      r_mem_ready <= w_mem_ready_nxt;
      r_mem_rdata <= w_mem_rdata_nxt;
      r_ram_wen   <= w_ram_wen_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_wdata <= w_ram_wdata_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wstrb     <= w_wstrb_nxt;
    end
  end

  assign mem_ready = r_mem_ready;
  assign mem_rdata = r_mem_rdata;
  assign ram_wen   = r_ram_wen;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;

endmodule

`default_nettype wire

// File: tb/tb_picorv_mem_responder.sv
// ============================================================================
// tb_picorv_mem_responder
// Randomized self-checking bench with an array-based memory reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_picorv_mem_responder;

  localparam logic [31:0] BASE = 32'h0000_1C00;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        ram_wen;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  picorv_mem_responder #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM attached to the bridge.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (ram_wen) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  logic [31:0] ref_mem [256];
  logic [31:0] last_rd;
  int          n_cmp = 0;
  int          n_bad = 0;

  int          lat, pl, e_lat, e_pl;
  logic [31:0] rd, ww, e_word;
  logic [7:0]  wa;

  // Reference: latency, pulse count and resulting word from the access rules.
  function automatic void model(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, output int x_lat,
                                output int x_pl, output logic [31:0] x_word);
    int idx;
    logic [31:0] w;
    idx = int'(addr[9:2]);
    w   = ref_mem[idx];
    if (wstrb == 4'h0) begin
      x_lat   = 3;
      x_pl    = 0;
      last_rd = w;
    end else begin
      x_lat = (wstrb == 4'hF) ? 2 : 4;
      x_pl  = 1;
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) w = (w & ~(32'hFF << (8*b))) | (wdata & (32'hFF << (8*b)));
      ref_mem[idx] = w;
    end
    x_word = w;
  endfunction

  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input bit scramble,
                        output int o_lat, output logic [31:0] o_rd, output int o_pl,
                        output logic [7:0] o_wa, output logic [31:0] o_ww);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    o_lat = 0; o_pl = 0; o_rd = '0; o_wa = '0; o_ww = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ram_wen) begin o_pl++; o_wa = ram_addr; o_ww = ram_wdata; end
      if (scramble) begin
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_wstrb = 4'($urandom);
      end
      if (mem_ready) begin o_lat = k; o_rd = mem_rdata; break; end
    end
    n_cmp++;
    if (o_lat == 0) begin
      n_bad++;
      $display("FAIL req_timeout: no mem_ready within 20 cycles, addr=%h", addr);
    end else begin
      // Keep the request on the bus through the ACK edge.
      @(posedge clk); #1;
      if (ram_wen) o_pl++;
      n_cmp++;
      if (mem_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL ack_single: mem_ready=%b required 0 one cycle after ACK", mem_ready);
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; mem_valid = 1'b1; mem_addr = BASE; mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'hF;
    #1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({mem_ready, ram_wen, ram_addr, ram_wdata, mem_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: ready=%b wen=%b addr=%h wdata=%h rdata=%h required all 0",
               mem_ready, ram_wen, ram_addr, ram_wdata, mem_rdata);
    end
    mem_valid = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;
    last_rd = '0;
  endtask

  task automatic test_read();
    model(BASE + 32'h14, 32'h0, 4'h0, e_lat, e_pl, e_word);
    do_req(BASE + 32'h14, 32'h0, 4'h0, 1'b0, lat, rd, pl, wa, ww);
    mem_valid = 1'b0;
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL read_latency: got %0d required 3", lat); end
    n_cmp++; if (rd !== 32'hAABBCCDD) begin n_bad++; $display("FAIL read_data: got %h required aabbccdd", rd); end
    n_cmp++; if (pl != 0) begin n_bad++; $display("FAIL read_no_wen: got %0d pulses required 0", pl); end
  endtask

  task automatic test_full_write();
    model(BASE + 32'h08, 32'h12345678, 4'hF, e_lat, e_pl, e_word);
    do_req(BASE + 32'h08, 32'h12345678, 4'hF, 1'b0, lat, rd, pl, wa, ww);
    mem_valid = 1'b0;
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL full_latency: got %0d required 2", lat); end
    n_cmp++; if (pl != 1) begin n_bad++; $display("FAIL full_wen_pulses: got %0d required 1", pl); end
    n_cmp++; if (wa !== 8'd2) begin n_bad++; $display("FAIL full_ram_addr: got %0d required 2", wa); end
    n_cmp++; if (ww !== 32'h12345678) begin n_bad++; $display("FAIL full_ram_wdata: got %h required 12345678", ww); end
    n_cmp++; if (mem_rdata !== last_rd) begin n_bad++; $display("FAIL rdata_hold: got %h required %h", mem_rdata, last_rd); end
    model(BASE + 32'h08, 32'h0, 4'h0, e_lat, e_pl, e_word);
    do_req(BASE + 32'h0B, 32'h0, 4'h0, 1'b0, lat, rd, pl, wa, ww);
    mem_valid = 1'b0;
    n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL full_readback: got %h required 12345678", rd); end
  endtask

  task automatic test_partial_write();
    model(BASE + 32'h0C, 32'hAABBCCDD, 4'b0101, e_lat, e_pl, e_word);
    do_req(BASE + 32'h0C, 32'hAABBCCDD, 4'b0101, 1'b0, lat, rd, pl, wa, ww);
    mem_valid = 1'b0;
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL partial_latency: got %0d required 4", lat); end
    n_cmp++; if (pl != 1) begin n_bad++; $display("FAIL partial_wen_pulses: got %0d required 1", pl); end
    n_cmp++; if (wa !== 8'd3) begin n_bad++; $display("FAIL partial_ram_addr: got %0d required 3", wa); end
    n_cmp++; if (ww !== 32'h11BB33DD) begin n_bad++; $display("FAIL partial_ram_wdata: got %h required 11bb33dd", ww); end
  endtask

  task automatic test_unselected();
    mem_valid = 1'b1; mem_addr = BASE + 32'h400; mem_wdata = 32'hDEADBEEF; mem_wstrb = 4'hF;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k == 5) mem_wstrb = 4'h0;
      n_cmp++;
      if (mem_ready !== 1'b0 || ram_wen !== 1'b0) begin
        n_bad++;
        $display("FAIL unselected: cycle %0d ready=%b wen=%b required 0/0", k, mem_ready, ram_wen);
      end
    end
    mem_valid = 1'b0;
  endtask

  task automatic test_random(input int count, input bit back_to_back);
    logic [31:0] a, d;
    logic [3:0]  s;
    for (int t = 0; t < count; t++) begin
      a = BASE | ($urandom & 32'h3FF);
      d = $urandom;
      case ($urandom_range(0, 2))
        0:       s = 4'h0;
        1:       s = 4'hF;
        default: s = 4'($urandom_range(1, 14));
      endcase
      model(a, d, s, e_lat, e_pl, e_word);
      do_req(a, d, s, !back_to_back, lat, rd, pl, wa, ww);
      if (!back_to_back) begin
        mem_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      n_cmp++;
      if (lat != e_lat || pl != e_pl || rd !== last_rd) begin
        n_bad++;
        $display("FAIL rand_txn %0d: lat=%0d pulses=%0d rdata=%h required lat=%0d pulses=%0d rdata=%h",
                 t, lat, pl, rd, e_lat, e_pl, last_rd);
      end
      if (s != 4'h0) begin
        n_cmp++;
        if (wa !== a[9:2] || ww !== e_word) begin
          n_bad++;
          $display("FAIL rand_write %0d: addr=%h data=%h required addr=%h data=%h", t, wa, ww, a[9:2], e_word);
        end
      end
    end
    mem_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    mem_valid = 1'b1; mem_addr = BASE + 32'h1C; mem_wdata = $urandom; mem_wstrb = 4'b0011;
    repeat (2) begin @(posedge clk); #1; end
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({mem_ready, ram_wen, ram_addr, ram_wdata, mem_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: ready=%b wen=%b addr=%h wdata=%h rdata=%h required all 0",
               mem_ready, ram_wen, ram_addr, ram_wdata, mem_rdata);
    end
    mem_valid = 1'b0;
    last_rd = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (mem_ready !== 1'b0 || ram_wen !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_mid_quiet: cycle %0d ready=%b wen=%b required 0/0", k, mem_ready, ram_wen);
      end
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (ram[7] !== ref_mem[7]) begin
      n_bad++;
      $display("FAIL reset_mid_ram: word 7=%h required %h", ram[7], ref_mem[7]);
    end
    model(BASE + 32'h1C, 32'h0, 4'h0, e_lat, e_pl, e_word);
    do_req(BASE + 32'h1C, 32'h0, 4'h0, 1'b0, lat, rd, pl, wa, ww);
    mem_valid = 1'b0;
    n_cmp++;
    if (rd !== e_word || lat != 3) begin
      n_bad++;
      $display("FAIL reset_mid_readback: data=%h lat=%0d required %h/3", rd, lat, e_word);
    end
  endtask

  task automatic test_ram_image();
    int bad_words;
    bad_words = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) bad_words++;
    n_cmp++;
    if (bad_words != 0) begin
      n_bad++;
      $display("FAIL ram_image: %0d words differ from reference required 0", bad_words);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[5] = 32'hAABBCCDD; ref_mem[5] = 32'hAABBCCDD;
    ram[3] = 32'h11223344; ref_mem[3] = 32'h11223344;
    last_rd = '0;

    test_reset();
    test_read();
    test_full_write();
    test_partial_write();
    test_unselected();
    test_random(60, 1'b0);
    test_random(12, 1'b1);
    test_reset_mid();
    test_ram_image();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
